// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one downstream memory port between an instruction-fetch requester
// and a data/page-walk requester. Data normally wins a tie; after MAX_WAIT
// consecutive tie losses the fetch side is granted once. A one-cycle RELEASE
// state follows every transaction so a requester's stale valid is never
// served twice.
//
// Handshake: a requester raises x_valid with stable request fields and holds
// them until x_data_ok. The arbiter latches the winner's fields when it leaves
// IDLE. It presents them on m_* with m_valid=1 until m_data_ok. x_data_ok is a
// combinational one-cycle echo of m_data_ok for the current owner.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   i_valid, i_addr       fetch request
//   i_data_ok, i_data     fetch response (32-bit word selected by addr[2])
//   d_valid, d_addr, d_size, d_strobe, d_wdata   data request
//   d_data_ok, d_data     data response
//   m_valid, m_addr, m_size, m_strobe, m_wdata   shared downstream request
//   m_data_ok, m_data     shared downstream response
//   grant                 one-hot owner: bit0 fetch, bit1 data
//   dbg_state             current FSM state (IDLE=0, SERVE_I=1, SERVE_D=2,
//                         RELEASE=3)
//   dbg_starve_cnt        current fetch starvation count
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_data_ok,
    output logic [31:0] i_data,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_data_ok,
    output logic [63:0] d_data,
    output logic        m_valid,
    output logic [63:0] m_addr,
    output logic [2:0]  m_size,
    output logic [7:0]  m_strobe,
    output logic [63:0] m_wdata,
    input  logic        m_data_ok,
    input  logic [63:0] m_data,
    output logic [1:0]  grant,
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [2:0] FETCH_SIZE = 3'b010;

    state_t      state_q,      state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [63:0] addr_q,       addr_d;
    logic [2:0]  size_q,       size_d;
    logic [7:0]  strobe_q,     strobe_d;
    logic [63:0] wdata_q,      wdata_d;

    logic take_i;
    logic take_d;

    // Next-state, latch capture and response strobes.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        strobe_d     = strobe_q;
        wdata_d      = wdata_q;
        i_data_ok    = 1'b0;
        d_data_ok    = 1'b0;
        take_i       = 1'b0;
        take_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid && d_valid) begin
                    // Tie: data wins unless fetch has lost MAX_WAIT ties in a row.
                    if (starve_cnt_q == MAX_WAIT_C) begin
                        take_i = 1'b1;
                    end else begin
                        take_d       = 1'b1;
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (i_valid) begin
                    take_i = 1'b1;
                end else if (d_valid) begin
                    take_d = 1'b1;
                end

                if (take_i) begin
                    state_d      = SERVE_I;
                    starve_cnt_d = 4'd0;
                    addr_d       = i_addr;
                    size_d       = FETCH_SIZE;
                    strobe_d     = 8'h00;
                    wdata_d      = 64'h0;
                end else if (take_d) begin
                    state_d  = SERVE_D;
                    addr_d   = d_addr;
                    size_d   = d_size;
                    strobe_d = d_strobe;
                    wdata_d  = d_wdata;
                end
            end
            SERVE_I: begin
                if (m_data_ok) begin
                    i_data_ok = 1'b1;
                    state_d   = RELEASE;
                end
            end
            SERVE_D: begin
                if (m_data_ok) begin
                    d_data_ok = 1'b1;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A response arriving while reset is applied is abandoned.
        if (!reset) begin
            i_data_ok = 1'b0;
            d_data_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            addr_q       <= 64'h0;
            size_q       <= 3'b000;
            strobe_q     <= 8'h00;
            wdata_q      <= 64'h0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            strobe_q     <= strobe_d;
            wdata_q      <= wdata_d;
        end
    end

    assign m_valid  = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign m_addr   = addr_q;
    assign m_size   = size_q;
    assign m_strobe = strobe_q;
    assign m_wdata  = wdata_q;

    assign grant = {(state_q == SERVE_D), (state_q == SERVE_I)};

    // Fetch returns the 32-bit half of the 64-bit beat selected by addr[2].
    assign i_data = addr_q[2] ? m_data[63:32] : m_data[31:0];
    assign d_data = m_data;

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: consecutive fetch losses that force one fetch-priority grant (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every state element updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port i_valid, input, 1 bit: fetch request; the requester holds it until i_data_ok.
REQ-005 SHALL have port i_addr, input, 64 bits: fetch address.
REQ-006 SHALL have port i_data_ok, output, 1 bit: fetch response strobe.
REQ-007 SHALL have port i_data, output, 32 bits: fetched instruction.
REQ-008 SHALL have port d_valid, input, 1 bit: data or page-walk request; the requester holds it until d_data_ok.
REQ-009 SHALL have port d_addr, input, 64 bits: data address.
REQ-010 SHALL have port d_size, input, 3 bits: access size code.
REQ-011 SHALL have port d_strobe, input, 8 bits: byte write enables; all-zero means read.
REQ-012 SHALL have port d_wdata, input, 64 bits: write data.
REQ-013 SHALL have port d_data_ok, output, 1 bit: data response strobe.
REQ-014 SHALL have port d_data, output, 64 bits: read data.
REQ-015 SHALL have ports m_valid (output, 1), m_addr (output, 64), m_size (output, 3), m_strobe (output, 8), m_wdata (output, 64): the shared downstream request.
REQ-016 SHALL have ports m_data_ok (input, 1) and m_data (input, 64): the shared downstream response.
REQ-017 SHALL have port grant, output, 2 bits: one-hot owner, bit0 = fetch, bit1 = data, 00 = none.

Function
REQ-018 SHALL implement four states: IDLE, SERVE_I, SERVE_D, RELEASE.
REQ-019 In IDLE, when only i_valid is high, it SHALL go to SERVE_I; when only d_valid is high, it SHALL go to SERVE_D; when neither is high, it SHALL stay in IDLE.
REQ-020 In IDLE with both valids high, it SHALL go to SERVE_D, except when starve_cnt == MAX_WAIT, in which case it SHALL go to SERVE_I.
REQ-021 starve_cnt (4 bits) SHALL be incremented, saturating at MAX_WAIT, when a tie grants SERVE_D; it SHALL be cleared on every entry to SERVE_I.
REQ-022 On leaving IDLE, the winner's address, size, strobe and wdata SHALL be latched; the fetch path latches size=3'b010 and strobe=0.
REQ-023 m_* outputs SHALL drive only the latched values; later changes on requester inputs SHALL be ignored for the rest of the transaction.
REQ-024 m_valid SHALL be 1 exactly in SERVE_I and SERVE_D; it SHALL first assert the cycle after the request is seen in IDLE (one-cycle arbitration latency).
REQ-025 grant SHALL be 01 in SERVE_I, 10 in SERVE_D, and 00 otherwise.
REQ-026 In SERVE_x with m_data_ok=1, it SHALL pulse x_data_ok combinationally in that cycle and go to RELEASE.
REQ-027 In SERVE_x with m_data_ok=0, it SHALL hold the state with no timeout.
REQ-028 i_data SHALL equal m_data[63:32] when latched addr[2]=1, and m_data[31:0] otherwise.
REQ-029 d_data SHALL equal m_data unmodified.
REQ-030 Data outputs are don't-care when their data_ok is 0.
REQ-031 i_data_ok and d_data_ok SHALL never both be 1; each pulse SHALL last exactly one cycle per transaction.
REQ-032 m_data_ok SHALL be ignored in IDLE and RELEASE, with no pulse and no state change.
REQ-033 RELEASE SHALL last one cycle with m_valid=0 and SHALL then go to IDLE.
REQ-034 RELEASE exists so a requester's stale valid is never re-served; the minimum turnaround is request to request in 3 cycles.
REQ-035 A requester that keeps valid high after RELEASE SHALL be treated as a new request.

Reset
REQ-036 With reset=0 at a rising edge, it SHALL set state=IDLE, starve_cnt=0, m_valid=0, grant=00, latched fields=0, i_data_ok=0 and d_data_ok=0, regardless of state.
REQ-037 Reset during SERVE_x SHALL abandon the transaction; a later m_data_ok SHALL be dropped under REQ-032.
REQ-038 After reset releases, arbitration SHALL resume on the first cycle with reset=1.

Verification
REQ-039 Scenario: fetch only, i_addr=0x8000_0004, m_data_ok 3 cycles after m_valid, m_data=0x1111_2222_3333_4444 -> m_addr=0x8000_0004, i_data=0x1111_2222, one i_data_ok pulse, grant 01 then 00.
REQ-040 Scenario: both valid from reset with MAX_WAIT=4, 1-cycle memory -> grants D, D, D, D, then I on the 5th tie; starve_cnt returns to 0.
REQ-041 Scenario: data write, d_strobe=0xFF, d_wdata=0xDEAD_BEEF_0000_0001; d_wdata is changed mid-SERVE_D -> m_wdata stays 0xDEAD_BEEF_0000_0001 until RELEASE.
REQ-042 Scenario: m_data_ok pulsed in IDLE and in RELEASE -> no data_ok output, state unchanged.
REQ-043 Scenario: reset=0 two cycles into SERVE_I, then m_data_ok=1 after release -> m_valid=0, grant=00, i_data_ok never asserts.
REQ-044 Scenario: i_valid held high continuously -> m_valid is low for at least 2 cycles between transactions, and each transaction gives exactly one i_data_ok.
